// File: rtl/i2c_bus_mon_pkg.sv
// Shared definitions for the I2C slave front end.
// Bit map of the one-cycle transition bus consumed by the rx/tx paths.
package i2c_bus_mon_pkg;

  localparam int T_BUSSIZE = 5;

  localparam int T_SCL     = 0;
  localparam int T_LASTSDA = 1;
  localparam int T_SCLRISE = 2;
  localparam int T_SCLFALL = 3;
  localparam int T_START   = 4;
  localparam int T_STOP    = 5;

  typedef logic [T_BUSSIZE:0] i2ctrans_t;

endpackage

// File: rtl/i2c_pin_filt.sv
// Two-flop synchroniser plus stable-count glitch filter for one I2C pin.
// Idles high; exposes the filtered level and its next-state value.
module i2c_pin_filt #(
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_i,
  output logic f_o,
  output logic f_d_o
);

  localparam logic [3:0] CMAX = 4'(FILT_LEN - 1);

  logic       s1_q;
  logic       s2_q;
  logic       f_q;
  logic       f_d;
  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    f_d   = f_q;
    cnt_d = '0;
    if (s2_q != f_q) begin
      if (cnt_q == CMAX) begin
        f_d = s2_q;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q  <= 1'b1;
      s2_q  <= 1'b1;
      f_q   <= 1'b1;
      cnt_q <= '0;
    end else begin
      s1_q  <= pin_i;
      s2_q  <= s1_q;
      f_q   <= f_d;
      cnt_q <= cnt_d;
    end
  end

  assign f_o   = f_q;
  assign f_d_o = f_d;

endmodule

// File: rtl/i2c_bus_mon.sv
// I2C bus monitor: filtered pins, edge/START/STOP pulses and bus-busy tracking.
// Pulses are registered so they line up with the filtered level change.
module i2c_bus_mon
  import i2c_bus_mon_pkg::*;
#(
  parameter int FILT_LEN = 3,
  parameter int IDLE_CNT = 1023
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scl_in,
  input  logic             sda_in,
  output logic [T_BUSSIZE:0] i2ctrans,
  output logic             bus_busy
);

  localparam int IW = $clog2(IDLE_CNT + 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_CNT - 1);

  logic scl_f, scl_n;
  logic sda_f, sda_n;

  i2c_pin_filt #(.FILT_LEN(FILT_LEN)) u_scl (
    .clk   (clk),
    .rst   (rst),
    .pin_i (scl_in),
    .f_o   (scl_f),
    .f_d_o (scl_n)
  );

  i2c_pin_filt #(.FILT_LEN(FILT_LEN)) u_sda (
    .clk   (clk),
    .rst   (rst),
    .pin_i (sda_in),
    .f_o   (sda_f),
    .f_d_o (sda_n)
  );

  // START/STOP need SCL high on both sides, so a coincident SCL edge masks them
  logic rise_d, fall_d, start_d, stop_d;
  assign rise_d  = scl_n & ~scl_f;
  assign fall_d  = ~scl_n & scl_f;
  assign start_d = sda_f & ~sda_n & scl_n & scl_f;
  assign stop_d  = ~sda_f & sda_n & scl_n & scl_f;

  logic          rise_q, fall_q, start_q, stop_q;
  logic          last_q;
  logic          busy_q;
  logic [IW-1:0] idle_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      idle_q  <= '0;
    end else begin
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      if (rise_d) begin
        last_q <= sda_n;
      end
      if (start_q) begin
        busy_q <= 1'b1;
      end else if (stop_q || idle_q == IDLE_MAX) begin
        busy_q <= 1'b0;
      end
      if (busy_q & scl_f & sda_f) begin
        if (idle_q != IDLE_MAX) begin
          idle_q <= idle_q + IW'(1);
        end
      end else begin
        idle_q <= '0;
      end
    end
  end

  always_comb begin
    i2ctrans            = '0;
    i2ctrans[T_SCL]     = scl_f;
    i2ctrans[T_LASTSDA] = last_q;
    i2ctrans[T_SCLRISE] = rise_q;
    i2ctrans[T_SCLFALL] = fall_q;
    i2ctrans[T_START]   = start_q;
    i2ctrans[T_STOP]    = stop_q;
  end

  assign bus_busy = busy_q;

endmodule

// File: tb/tb_i2c_bus_mon.sv
// Self-checking bench for i2c_bus_mon: directed bus scenarios plus random pins.
// A sample-history reference model predicts every output on every cycle.
module tb_i2c_bus_mon;

  localparam int FL = 3;
  localparam int IC = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_in;
  logic       sda_in;
  logic [5:0] i2ctrans;
  logic       bus_busy;

  always #5 clk = ~clk;

  i2c_bus_mon #(.FILT_LEN(FL), .IDLE_CNT(IC)) dut (
    .clk      (clk),
    .rst      (rst),
    .scl_in   (scl_in),
    .sda_in   (sda_in),
    .i2ctrans (i2ctrans),
    .bus_busy (bus_busy)
  );

  int nasrt = 0;
  int nfail = 0;
  int n_rise = 0, n_fall = 0, n_start = 0, n_stop = 0;

  bit hs[$];
  bit hd[$];
  bit m_scl, m_sda, m_last, m_rise, m_fall, m_start, m_stop, m_busy;
  int m_idle;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nasrt++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic hist_fill();
    hs.delete();
    hd.delete();
    for (int k = 0; k < FL + 2; k++) begin
      hs.push_back(1'b1);
      hd.push_back(1'b1);
    end
  endtask

  // A filtered level flips once the last FL synchronised samples all disagree with it
  task automatic step();
    bit ns, nd, fs, fd, nb;
    int ni;
    @(posedge clk);
    if (rst) begin
      hist_fill();
      m_scl = 1; m_sda = 1; m_last = 0;
      m_rise = 0; m_fall = 0; m_start = 0; m_stop = 0;
      m_busy = 0; m_idle = 0;
    end else begin
      hs.push_front(scl_in);
      hd.push_front(sda_in);
      while (hs.size() > FL + 2) void'(hs.pop_back());
      while (hd.size() > FL + 2) void'(hd.pop_back());
      fs = 1; fd = 1;
      for (int k = 2; k < FL + 2; k++) begin
        if (hs[k] == m_scl) fs = 0;
        if (hd[k] == m_sda) fd = 0;
      end
      ns = fs ? ~m_scl : m_scl;
      nd = fd ? ~m_sda : m_sda;
      nb = m_busy;
      if (m_start) nb = 1;
      else if (m_stop || m_idle == IC - 1) nb = 0;
      ni = (m_busy && m_scl && m_sda) ? ((m_idle == IC - 1) ? m_idle : m_idle + 1) : 0;
      m_rise  = ns & ~m_scl;
      m_fall  = ~ns & m_scl;
      m_start = m_sda & ~nd & ns & m_scl;
      m_stop  = ~m_sda & nd & ns & m_scl;
      if (m_rise) m_last = nd;
      m_scl = ns; m_sda = nd; m_busy = nb; m_idle = ni;
    end
    #1;
    chk("trans", {2'b00, i2ctrans},
        {2'b00, m_stop, m_start, m_fall, m_rise, m_last, m_scl});
    chk("busy", {7'd0, bus_busy}, {7'd0, m_busy});
    n_rise  += int'(i2ctrans[2]);
    n_fall  += int'(i2ctrans[3]);
    n_start += int'(i2ctrans[4]);
    n_stop  += int'(i2ctrans[5]);
  endtask

  initial begin
    logic [7:0] byte_v;
    int r0, f0, s0;
    hist_fill();
    rst = 1; scl_in = 0; sda_in = 0;
    repeat (3) step();
    rst = 0; scl_in = 1; sda_in = 1;
    step();
    chk("rst_trans", {2'b00, i2ctrans}, 8'h01);
    chk("rst_busy", {7'd0, bus_busy}, 8'h00);
    repeat (10) step();
    chk("rst_pulses", 8'(n_rise + n_fall + n_start + n_stop), 8'd0);

    sda_in = 0;
    repeat (4) step();
    chk("start_early", {7'd0, i2ctrans[4]}, 8'd0);
    step();
    chk("start_lat", {7'd0, i2ctrans[4]}, 8'd1);
    chk("busy_pre", {7'd0, bus_busy}, 8'd0);
    step();
    chk("busy_set", {7'd0, bus_busy}, 8'd1);

    r0 = n_rise; f0 = n_fall; s0 = n_stop;
    byte_v = 8'hA5;
    for (int i = 7; i >= 0; i--) begin
      scl_in = 0; repeat (5) step();
      sda_in = byte_v[i]; repeat (5) step();
      scl_in = 1; repeat (10) step();
      chk("lastsda", {7'd0, i2ctrans[1]}, {7'd0, byte_v[i]});
    end
    chk("byte_rises", 8'(n_rise - r0), 8'd8);
    chk("byte_falls", 8'(n_fall - f0), 8'd8);

    scl_in = 0; repeat (5) step();
    sda_in = 0; repeat (5) step();
    scl_in = 1; repeat (8) step();
    r0 = n_rise; f0 = n_fall;
    scl_in = 0; repeat (2) step();
    scl_in = 1; repeat (8) step();
    chk("glitch2_fall", 8'(n_fall - f0), 8'd0);
    chk("glitch2_rise", 8'(n_rise - r0), 8'd0);
    scl_in = 0; repeat (3) step();
    scl_in = 1; repeat (8) step();
    chk("glitch3_fall", 8'(n_fall - f0), 8'd1);
    chk("glitch3_rise", 8'(n_rise - r0), 8'd1);

    scl_in = 0; repeat (6) step();
    scl_in = 1; sda_in = 1;
    repeat (5) step();
    chk("simul_rise", {7'd0, i2ctrans[2]}, 8'd1);
    chk("simul_nostop", {7'd0, i2ctrans[5]}, 8'd0);
    repeat (15) step();
    chk("idle_hold", {7'd0, bus_busy}, 8'd1);
    step();
    chk("idle_drop", {7'd0, bus_busy}, 8'd0);
    chk("idle_nostop", 8'(n_stop - s0), 8'd0);

    sda_in = 0; repeat (6) step();
    chk("busy_again", {7'd0, bus_busy}, 8'd1);
    scl_in = 0; repeat (6) step();
    sda_in = 1; repeat (3) step();
    rst = 1; step();
    chk("rst_mid_busy", {7'd0, bus_busy}, 8'd0);
    chk("rst_mid_trans", {2'b00, i2ctrans}, 8'h01);
    rst = 0;

    repeat (300) begin
      scl_in = 1'($urandom);
      sda_in = 1'($urandom);
      repeat ($urandom_range(1, 6)) step();
      if ($urandom_range(0, 49) == 0) begin
        rst = 1;
        repeat ($urandom_range(1, 2)) step();
        rst = 0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nasrt, nfail);
    $finish;
  end

endmodule
